// File: rtl/demux_pkg.sv
// Shared select encodings and output count for the 1-to-4 demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_OUT = 4;

  localparam logic [1:0] SEL_OUT0 = 2'd0;
  localparam logic [1:0] SEL_OUT1 = 2'd1;
  localparam logic [1:0] SEL_OUT2 = 2'd2;
  localparam logic [1:0] SEL_OUT3 = 2'd3;

endpackage

// File: rtl/decoder_2to4.sv
// Combinational 2-to-4 decoder producing a one-hot output enable from the select.
module decoder_2to4
  import demux_pkg::*;
(
  input  logic [1:0]         sel,
  output logic [NUM_OUT-1:0] en
);

  always_comb begin
    en = '0;
    unique case (sel)
      SEL_OUT0: en = 4'b0001;
      SEL_OUT1: en = 4'b0010;
      SEL_OUT2: en = 4'b0100;
      SEL_OUT3: en = 4'b1000;
      default:  en = '0;
    endcase
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: din is routed to the selected output, all others
// are cleared, and every output is recomputed on each rising clock edge.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic [DATA_W-1:0] dout_2,
  output logic [DATA_W-1:0] dout_3
);

  logic [NUM_OUT-1:0] en;

  decoder_2to4 u_decoder (
    .sel (sel),
    .en  (en)
  );

  // Unselected outputs load zero rather than holding, so only one output is ever non-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_0 <= '0;
      dout_1 <= '0;
      dout_2 <= '0;
      dout_3 <= '0;
    end else begin
      dout_0 <= din & {DATA_W{en[0]}};
      dout_1 <= din & {DATA_W{en[1]}};
      dout_2 <= din & {DATA_W{en[2]}};
      dout_3 <= din & {DATA_W{en[3]}};
    end
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4 at DATA_W=1 and DATA_W=8, driven by directed vectors.
module tb_demux_1to4;

  typedef struct packed {
    logic [3:0]  e1;
    logic [31:0] e8;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din1;
  logic [7:0] din8;
  logic [1:0] sel;
  logic       d1_0, d1_1, d1_2, d1_3;
  logic [7:0] d8_0, d8_1, d8_2, d8_3;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  demux_1to4 #(.DATA_W(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .din    (din1),
    .sel    (sel),
    .dout_0 (d1_0),
    .dout_1 (d1_1),
    .dout_2 (d1_2),
    .dout_3 (d1_3)
  );

  demux_1to4 #(.DATA_W(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .din    (din8),
    .sel    (sel),
    .dout_0 (d8_0),
    .dout_1 (d8_1),
    .dout_2 (d8_2),
    .dout_3 (d8_3)
  );

  // Monitor: each expectation pushed before an edge is checked just after that edge.
  always begin
    exp_t       e;
    logic [3:0]  got1;
    logic [31:0] got8;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e    = q.pop_front();
      got1 = {d1_3, d1_2, d1_1, d1_0};
      got8 = {d8_3, d8_2, d8_1, d8_0};
      tests++;
      if (got1 !== e.e1) begin
        fails++;
        $display("FAIL w1_outputs: got %b required %b", got1, e.e1);
      end
      tests++;
      if (got8 !== e.e8) begin
        fails++;
        $display("FAIL w8_outputs: got %h required %h", got8, e.e8);
      end
    end
  end

  task automatic apply(input logic r, input logic d1, input logic [7:0] d8,
                       input logic [1:0] s, input logic [3:0] e1, input logic [31:0] e8);
    exp_t e;
    @(negedge clk);
    rst  = r;
    din1 = d1;
    din8 = d8;
    sel  = s;
    e.e1 = e1;
    e.e8 = e8;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    int budget;
    rst  = 1'b1;
    din1 = 1'b0;
    din8 = 8'h00;
    sel  = 2'd0;

    // Reset held two cycles with live data present
    apply(1'b1, 1'b1, 8'hA5, 2'd3, 4'b0000, 32'h0000_0000);
    apply(1'b1, 1'b1, 8'hA5, 2'd3, 4'b0000, 32'h0000_0000);
    // Sweep
    apply(1'b0, 1'b1, 8'hA5, 2'd0, 4'b0001, 32'h0000_00A5);
    apply(1'b0, 1'b1, 8'hA5, 2'd1, 4'b0010, 32'h0000_A500);
    apply(1'b0, 1'b1, 8'hA5, 2'd2, 4'b0100, 32'h00A5_0000);
    apply(1'b0, 1'b1, 8'hA5, 2'd3, 4'b1000, 32'hA500_0000);
    // Zero data
    apply(1'b0, 1'b0, 8'h00, 2'd0, 4'b0000, 32'h0000_0000);
    apply(1'b0, 1'b0, 8'h00, 2'd1, 4'b0000, 32'h0000_0000);
    apply(1'b0, 1'b0, 8'h00, 2'd2, 4'b0000, 32'h0000_0000);
    apply(1'b0, 1'b0, 8'h00, 2'd3, 4'b0000, 32'h0000_0000);
    // Back-to-back switching
    apply(1'b0, 1'b1, 8'h3C, 2'd0, 4'b0001, 32'h0000_003C);
    apply(1'b0, 1'b1, 8'h3C, 2'd3, 4'b1000, 32'h3C00_0000);
    apply(1'b0, 1'b1, 8'h3C, 2'd0, 4'b0001, 32'h0000_003C);
    apply(1'b0, 1'b1, 8'h3C, 2'd3, 4'b1000, 32'h3C00_0000);
    // Reset mid-stream, then release with a new select
    apply(1'b0, 1'b1, 8'hFF, 2'd2, 4'b0100, 32'h00FF_0000);
    apply(1'b1, 1'b1, 8'hFF, 2'd2, 4'b0000, 32'h0000_0000);
    apply(1'b0, 1'b1, 8'h81, 2'd1, 4'b0010, 32'h0000_8100);
    // Wide data on one lane while the narrow instance sees zero
    apply(1'b0, 1'b0, 8'hA5, 2'd2, 4'b0000, 32'h00A5_0000);

    budget = 0;
    while (q.size() > 0 && budget < 5) begin
      @(posedge clk);
      budget++;
    end
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
